// File: rtl/gray_seq_ctrl_pkg.sv
// Shared state encoding and direction constants for the Gray-code sequencer.
package gray_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/gray_seq_ctrl_bin2gray_w.sv
// Combinational binary-to-Gray converter of parameterisable width.
module bin2gray_w #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g
);

    assign g = b ^ (b >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Steps a binary count up or down and streams each value as Gray code over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; outputs idle, count holds its last value
// EMIT  | presenting the current code; advance on each transfer
// DONE  | one-cycle done pulse after the final transfer
module gray_seq_ctrl
    import gray_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] start_bin,
    input  logic [WIDTH-1:0] nsteps,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_gray;
    logic             r_dir;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_xfer;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_gray_nxt;

    assign w_xfer = r_valid & out_ready;

    // The Gray output is converted from the next count so it lands on the same edge as bin_out.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == IDLE && start) begin
            w_cnt_nxt = start_bin;
        end else if (r_state == EMIT && !abort && w_xfer && r_rem != '0) begin
            w_cnt_nxt = (r_dir == DIR_UP) ? r_cnt + 1'b1 : r_cnt - 1'b1;
        end
    end

    bin2gray_w #(.WIDTH(WIDTH)) u_bin2gray (
        .b (w_cnt_nxt),
        .g (w_gray_nxt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_gray  <= '0;
            r_dir   <= DIR_UP;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_gray <= w_gray_nxt;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dir   <= dir ? DIR_UP : DIR_DN;
                        r_rem   <= nsteps;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    // Abort wins over completion: a transfer in the same cycle is accepted but no done pulse follows.
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_xfer) begin
                        if (r_rem == '0) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_rem <= r_rem - 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign gray_out  = r_gray;
    assign bin_out   = r_cnt;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
